menu_typewriter: RTL and testbench

Typewriter-style reveal controller for menu text pages. It sits between the character renderer and a menu text ROM (char_xy → char_code, one-cycle registered latency). It sequences how many characters of the 16×16 page are visible, advancing one character every N frames. Positions not yet revealed are masked to SPACE, so menu pages appear to type themselves out.

---
 rtl/vga_pkg.sv | 13 +
 rtl/menu_typewriter_frame_div.sv | 33 +++
 rtl/menu_typewriter.sv | 118 +++++++++++
 tb/tb_menu_typewriter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared character-code constants and the typewriter state type for the menu text path.
package vga_pkg;

  localparam logic [6:0] SPACE  = 7'h20;
  localparam logic [6:0] CURSOR = 7'h5F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    DONE   = 2'd2
  } typewriter_state_t;

endpackage

// File: rtl/menu_typewriter_frame_div.sv
// Frame divider: emits one char_step pulse every FRAMES_PER_CHAR frame_ticks while enabled.
module frame_div #(
  parameter int unsigned FRAMES_PER_CHAR = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic frame_tick,
  output logic char_step
);

  localparam logic [7:0] TERM = 8'(FRAMES_PER_CHAR - 1);

  logic [7:0] frame_cnt;
  logic       at_term;

  assign at_term = (frame_cnt == TERM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 8'd0;
    end else if (clr) begin
      frame_cnt <= 8'd0;
    end else if (en && frame_tick) begin
      frame_cnt <= at_term ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  // A restart in the same cycle swallows the step so the new page begins at zero.
  assign char_step = en & frame_tick & at_term & ~clr;

endmodule

// File: rtl/menu_typewriter.sv
// Typewriter reveal controller: masks unrevealed menu page positions to SPACE.
// Optional blinking cursor at the reveal point: define MENU_TYPEWRITER_CURSOR_EN.
//
// state  | meaning
// IDLE   | nothing revealed, page blank
// TYPING | reveal_cnt advancing one position every FRAMES_PER_CHAR frames
// DONE   | page fully revealed, count frozen
module menu_typewriter
  import vga_pkg::*;
#(
  parameter int unsigned FRAMES_PER_CHAR = 2,
  parameter logic [7:0]  LAST_CHAR       = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       skip,
  input  logic       frame_tick,
  input  logic [7:0] char_xy_in,
  output logic [7:0] char_xy_out,
  input  logic [6:0] rom_char_code,
  output logic [6:0] char_code,
  output logic [8:0] reveal_cnt,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] FULL = {1'b0, LAST_CHAR} + 9'd1;

  typewriter_state_t state, state_nxt;
  logic              typing;
  logic              char_step;
  logic [7:0]        xy_d1;
  logic [6:0]        code_nxt;

  assign typing      = (state == TYPING);
  assign char_xy_out = char_xy_in;

  frame_div #(
    .FRAMES_PER_CHAR(FRAMES_PER_CHAR)
  ) u_frame_div (
    .clk       (clk),
    .rst       (rst),
    .en        (typing),
    .clr       (start),
    .frame_tick(frame_tick),
    .char_step (char_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = TYPING;
      TYPING: begin
        if (start)                                      state_nxt = TYPING;
        else if (skip)                                  state_nxt = DONE;
        else if (char_step && reveal_cnt == FULL - 9'd1) state_nxt = DONE;
      end
      DONE:   if (start) state_nxt = TYPING;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == TYPING);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reveal_cnt <= 9'd0;
    end else if (start) begin
      reveal_cnt <= 9'd0;
    end else if (typing) begin
      if (skip)           reveal_cnt <= FULL;
      else if (char_step) reveal_cnt <= reveal_cnt + 9'd1;
    end
  end

`ifdef MENU_TYPEWRITER_CURSOR_EN
  logic [3:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     blink_cnt <= 4'd0;
    else if (start)               blink_cnt <= 4'd0;
    else if (typing && frame_tick) blink_cnt <= blink_cnt + 4'd1;
  end
`endif

  // xy_d1 lines up with the ROM's registered output; the mask sees the current count.
  always_comb begin
    code_nxt = SPACE;
    if ({1'b0, xy_d1} < reveal_cnt) begin
      code_nxt = rom_char_code;
    end
`ifdef MENU_TYPEWRITER_CURSOR_EN
    else if (typing && xy_d1 == reveal_cnt[7:0] && blink_cnt[3]) begin
      code_nxt = CURSOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xy_d1     <= 8'd0;
      char_code <= 7'd0;
    end else begin
      xy_d1     <= char_xy_in;
      char_code <= code_nxt;
    end
  end

endmodule

// File: tb/tb_menu_typewriter.sv
// Self-checking bench for menu_typewriter with a registered ROM stub and a char_code scoreboard.
module tb_menu_typewriter;

  localparam int unsigned FPC  = 2;
  localparam logic [7:0]  LAST = 8'h0F;
  localparam int          FULL = int'(LAST) + 1;
  localparam logic [6:0]  SP   = 7'h20;
  localparam logic [6:0]  CUR  = 7'h5F;
`ifdef MENU_TYPEWRITER_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       skip = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] char_xy_in = 8'd0;
  logic [7:0] char_xy_out;
  logic [6:0] rom_char_code = 7'd0;
  logic [6:0] char_code;
  logic [8:0] reveal_cnt;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 typing, 2 done
  int       m_state = 0;
  int       m_reveal = 0;
  int       m_fcnt = 0;
  int       m_blink = 0;
  logic [6:0] q[$];

  menu_typewriter #(
    .FRAMES_PER_CHAR(FPC),
    .LAST_CHAR      (LAST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .skip         (skip),
    .frame_tick   (frame_tick),
    .char_xy_in   (char_xy_in),
    .char_xy_out  (char_xy_out),
    .rom_char_code(rom_char_code),
    .char_code    (char_code),
    .reveal_cnt   (reveal_cnt),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_fn(input logic [7:0] a);
    return 7'h41 + 7'(a % 26);
  endfunction

  always @(posedge clk) rom_char_code <= rom_fn(char_xy_out);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_code(input int xy);
    if (xy < m_reveal) return rom_fn(8'(xy));
    if (CUR_EN && m_state == 1 && xy == (m_reveal % 256) && m_blink[3]) return CUR;
    return SP;
  endfunction

  task automatic chk_status();
    chk("reveal_cnt", 32'(reveal_cnt), 32'(m_reveal));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_state == 2));
  endtask

  task automatic sweep(input int lo, input int hi);
    q.delete();
    for (int i = lo; i <= hi + 2; i++) begin
      @(negedge clk);
      if (i >= lo + 2) chk("char_code", 32'(char_code), 32'(q.pop_front()));
      if (i <= hi) begin
        char_xy_in = 8'(i);
        q.push_back(exp_code(i));
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      if (m_state == 1) begin
        m_blink = (m_blink + 1) % 16;
        if (m_fcnt == int'(FPC) - 1) begin
          m_fcnt = 0;
          m_reveal++;
          if (m_reveal == FULL) m_state = 2;
        end else begin
          m_fcnt++;
        end
      end
      @(negedge clk);
      frame_tick = 1'b0;
      chk_status();
    end
  endtask

  task automatic pulse(input bit s, input bit k);
    @(negedge clk);
    start = s;
    skip  = k;
    if (s) begin
      m_state = 1; m_reveal = 0; m_fcnt = 0; m_blink = 0;
    end else if (k && m_state == 1) begin
      m_state = 2; m_reveal = FULL;
    end
    @(negedge clk);
    start = 1'b0;
    skip  = 1'b0;
    chk_status();
  endtask

  initial begin
    #1 rst = 1'b0;
    #11;
    chk("rst_char_code", 32'(char_code), 32'd0);
    chk_status();
    @(negedge clk) rst = 1'b1;

    sweep(0, 255);
    tick(3);
    pulse(1'b0, 1'b1);

    pulse(1'b1, 1'b0);
    tick(6);
    sweep(0, 5);

    tick(26);
    tick(10);
    sweep(8'h0E, 8'h12);

    pulse(1'b1, 1'b0);
    sweep(0, 8'h0F);
    tick(10);
    pulse(1'b0, 1'b1);
    sweep(3, 8'h11);
    pulse(1'b1, 1'b1);

    tick(14);
    @(negedge clk) char_xy_in = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_code", 32'(char_code), 32'(rom_fn(8'd0)));
    #2 rst = 1'b0;
    #1;
    m_state = 0; m_reveal = 0; m_fcnt = 0; m_blink = 0;
    chk("async_rst_code", 32'(char_code), 32'd0);
    chk_status();
    @(negedge clk) rst = 1'b1;
    sweep(0, 8'h12);

    pulse(1'b1, 1'b0);
    tick(8);
    sweep(3, 5);
    tick(2);
    sweep(4, 6);
    tick(6);
    sweep(7, 9);
    pulse(1'b0, 1'b1);
    sweep(8'h0E, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
